// File: rtl/dcp_pkg.sv
// Shared definitions for the debug control unit: FSM encodings, message
// types and the ASCII characters the formatters emit.
package dcp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_ACK  = 2'd2
   } tx_state_e;

   localparam logic TYPE_HEX = 1'b0;
   localparam logic TYPE_RAW = 1'b1;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_UA = 8'h41;
   localparam logic [7:0] ASCII_LA = 8'h61;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Bytes in one message: the digits plus the separator, or a lone raw byte.
   function automatic logic [3:0] msg_len(input logic msg_type, input int digits);
      if (msg_type == TYPE_RAW) begin
         return 4'd1;
      end
      return 4'(digits + 1);
   endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit to ASCII converter, shared by the debug commands
// that print numbers.
module nibble_to_ascii
   import dcp_pkg::*;
#(
   parameter bit UPPER = 1'b1
) (
   input  logic [3:0] nib,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = ASCII_0 + {4'h0, nib};
      if (nib > 4'd9) begin
         ascii = (UPPER ? ASCII_UA : ASCII_LA) + {4'h0, nib} - 8'd10;
      end
   end

endmodule

// File: rtl/hex_word_tx.sv
// Formats one 32-bit word (fixed-width hex plus separator) or one raw byte
// onto a valid/ready byte stream, handshaking with the command FSM via req/ack.
module hex_word_tx
   import dcp_pkg::*;
#(
   parameter int         DIGITS   = 8,
   parameter logic [7:0] SEP_CHAR = ASCII_SP,
   parameter bit         UPPER    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dout_tx,
   input  logic        type_tx,
   input  logic        req_tx,
   output logic        ack_tx,
   output logic [7:0]  d_tx,
   output logic        vld_tx,
   input  logic        rdy_tx
);

   localparam int TOP = 4 * DIGITS - 1;

   tx_state_e   state_q, state_d;
   logic [31:0] shreg_q, shreg_d;
   logic        type_q, type_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [7:0]  digit_ascii;
   logic [7:0]  byte_sel;
   logic        xfer;

   // The digit on the wire is always the top printable nibble; each accepted
   // byte shifts the next one into that position.
   nibble_to_ascii #(
      .UPPER (UPPER)
   ) u_nib (
      .nib   (shreg_q[TOP -: 4]),
      .ascii (digit_ascii)
   );

   always_comb begin
      byte_sel = digit_ascii;
      if (type_q == TYPE_RAW) begin
         byte_sel = shreg_q[7:0];
      end else if (cnt_q == 4'd1) begin
         byte_sel = SEP_CHAR;
      end
   end

   // Outputs depend only on registers, never on rdy_tx.
   assign vld_tx = (state_q == ST_SEND);
   assign ack_tx = (state_q == ST_ACK);
   assign d_tx   = vld_tx ? byte_sel : 8'h00;
   assign xfer   = vld_tx && rdy_tx;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_tx) begin
               shreg_d = dout_tx;
               type_d  = type_tx;
               cnt_d   = msg_len(type_tx, DIGITS);
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               shreg_d = shreg_q << 4;
               cnt_d   = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            // Only a low req returns to IDLE, so a held req cannot restart.
            if (!req_tx) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shreg_q <= 32'h0;
         type_q  <= TYPE_HEX;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/hex_word_tx.md
Name: hex_word_tx

Overview:
Transmit-side formatter for the debug control unit.
- Takes one 32-bit word plus a type bit from a command FSM over a four-phase req/ack handshake.
- Serialises the word into ASCII bytes on a valid/ready byte stream feeding the UART TX path.
- Type 0 prints the word as fixed-width hex with a trailing separator. Type 1 sends dout_tx[7:0] as one raw byte (CR/LF, prompt characters).

Parameters:
DIGITS, 8, number of hex digits printed for type 0, MSB nibble first; legal range 1..8.
SEP_CHAR, 8'h20, separator byte appended after the digits for type 0.
UPPER, 1, 1 prints hex letters as 'A'-'F' (0x41..0x46); 0 prints 'a'-'f' (0x61..0x66).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
dout_tx  input  32  word to print; sampled only at request acceptance
type_tx  input  1  0 = hex word + SEP_CHAR, 1 = raw byte dout_tx[7:0]; sampled with dout_tx
req_tx  input  1  request, level; held high until ack_tx seen
ack_tx  output  1  completion; high from the cycle after the last byte is accepted until req_tx is low
d_tx  output  8  byte to transmit
vld_tx  output  1  d_tx valid
rdy_tx  input  1  downstream ready; byte transfers on the rising clk edge where vld_tx && rdy_tx

Behaviour:
- Reset (async): state IDLE, vld_tx=0, ack_tx=0, d_tx=8'h00, counter=0, data/type registers cleared.
- States: IDLE, SEND, ACK.
- IDLE:
  - req_tx=1 on an edge: latch dout_tx into a shift register and latch type_tx.
  - Load remaining-byte count: DIGITS+1 for type 0, 1 for type 1.
  - Go to SEND.
  - vld_tx=0 and ack_tx=0 in IDLE.
- SEND:
  - vld_tx=1 from the first cycle after acceptance. Latency from req to the first valid byte is 1 cycle.
  - Type 0: bytes 1..DIGITS are the ASCII of nibbles [4*DIGITS-1 -: 4] down to [3:0]. The last byte is SEP_CHAR.
  - Type 1: the single byte is the latched dout_tx[7:0], unmodified.
  - Nibble mapping: 0..9 -> 8'h30+n; 10..15 -> (UPPER ? 8'h41 : 8'h61)+n-10.
  - d_tx and vld_tx are driven from registers, or combinationally from registers only; no combinational path from rdy_tx.
  - On each vld_tx && rdy_tx edge: advance to the next byte and decrement the count. The next byte is valid in the following cycle, so with rdy_tx held high there is one byte per cycle with no bubbles.
  - When vld_tx && !rdy_tx: d_tx must be held stable and vld_tx must stay high. vld_tx is never withdrawn once raised, except by reset.
  - Accepting the last byte (count == 1): go to ACK; vld_tx=0 in the next cycle.
- ACK:
  - ack_tx=1 while req_tx=1.
  - When req_tx is sampled 0: go to IDLE; ack_tx=0 from the next cycle.
  - A held req_tx never restarts a transmission. A new request needs req_tx low for at least one edge.
- req_tx changes while in SEND are ignored. dout_tx/type_tx changes after acceptance are ignored.
- Reset mid-operation: vld_tx and ack_tx drop immediately (async). The partial message is discarded and is not resumed.
- Total cycles, type 0, rdy_tx always 1: req edge -> DIGITS+1 transfer cycles -> ack_tx high on cycle DIGITS+2.

Decomposition:
- Shared package (dcp_pkg): state encoding for IDLE/SEND/ACK, TYPE_HEX=1'b0, TYPE_RAW=1'b1, ASCII constants (ASCII_0=8'h30, ASCII_UA=8'h41, ASCII_LA=8'h61, ASCII_SP=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A).
- One combinational sub-module: nibble_to_ascii (4-bit in, UPPER parameter, 8-bit out). It is reusable by other debug commands.

Test Plan:
- Word 0x1234ABCD, type 0, rdy_tx=1 constant -> d_tx 31 32 33 34 41 42 43 44 20 on 9 consecutive cycles starting 1 cycle after req; ack_tx rises the cycle after the 0x20 transfer.
- Word 0xDEADBEEF, UPPER=0, rdy_tx toggling 1,0,0,1,... -> bytes "deadbeef " in order; d_tx and vld_tx stable through every stall; no byte duplicated or dropped.
- Type 1, dout_tx=0x0000000A -> exactly one byte 0x0A; ack_tx after the transfer; nibble formatting not applied.
- req_tx held high for 20 cycles after ack_tx -> no further vld_tx; ack_tx stays 1; after req_tx drops, ack_tx=0 next cycle; a new req starts a fresh message.
- rst asserted after 3 of 9 bytes of 0xFFFFFFFF -> vld_tx=0 and ack_tx=0 immediately; after release, a new request 0x00000000 prints "00000000 " from its first digit.
- DIGITS=2, word 0x000000C3 -> "C3 " (43 33 20); upper bits ignored.
